// File: rtl/fnd_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg
// Shared constants, FSM state type and the double-dabble nibble adjust helper
// for the 4-digit FND scan front end.
//
// Contents:
//   NUM_DIGITS  number of displayed decimal digits
//   MAX_VALUE   largest value that fits on the display; larger inputs saturate
//   BIN_W       width of the binary input value
//   BCD_W       width of one BCD digit
//   state_e     converter FSM states
//   dd_adjust   add-3 correction applied to each BCD nibble before a shift
// -----------------------------------------------------------------------------
package fnd_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned MAX_VALUE  = 9999;
    localparam int unsigned BIN_W      = 14;
    localparam int unsigned BCD_W      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    // A nibble of 5 or more would exceed 9 once doubled; adding 3 first makes
    // the shift carry into the next decade instead.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// fnd_scan_if
// Bundles the value/load request and the scanned display outputs of
// fnd_scan_ctrl.
//
// Signals:
//   i_value        binary value to display (driven by master)
//   i_load         capture request (driven by master)
//   o_busy         conversion in progress
//   o_overflow     last accepted value exceeded MAX_VALUE
//   o_digitSelect  active digit, 0 = least significant
//   o_bcd          BCD digit for o_digitSelect
//   o_en           digit enable, 0 blanks the digit
// Modports:
//   master  producer of values / consumer of the display outputs
//   slave   the scan controller itself
// -----------------------------------------------------------------------------
interface fnd_scan_if;
    import fnd_pkg::*;

    logic [BIN_W-1:0] i_value;
    logic             i_load;
    logic             o_busy;
    logic             o_overflow;
    logic [1:0]       o_digitSelect;
    logic [BCD_W-1:0] o_bcd;
    logic             o_en;

    modport master (
        output i_value,
        output i_load,
        input  o_busy,
        input  o_overflow,
        input  o_digitSelect,
        input  o_bcd,
        input  o_en
    );

    modport slave (
        input  i_value,
        input  i_load,
        output o_busy,
        output o_overflow,
        output o_digitSelect,
        output o_bcd,
        output o_en
    );

endinterface

// File: rtl/fnd_scan_ctrl_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Iterative double-dabble converter: one add-3/shift step per clock, BIN_W
// steps per conversion.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset; aborts a running conversion
//   start  begin a conversion of 'bin' (honoured only while idle)
//   bin    binary value, sampled with start
//   busy   high from the edge after start until the final step's edge
//   done   combinational, high during the cycle whose edge performs the last
//          step; 'bcd' is valid in that same cycle
//   bcd    four packed BCD digits, digit 0 in bits [3:0]
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [BIN_W-1:0]            bin,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_DIGITS*BCD_W-1:0] bcd
);

    localparam int unsigned BCD_ALL_W = NUM_DIGITS * BCD_W;
    localparam int unsigned SR_W      = BCD_ALL_W + BIN_W;
    localparam int unsigned CNT_W     = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    state_e           state_q, state_d;
    logic [SR_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SR_W-1:0]  adjusted;
    logic [SR_W-1:0]  stepped;

    // One double-dabble step: correct every BCD nibble, then shift the whole
    // {bcd, bin} register left by one.
    always_comb begin
        adjusted = shreg_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adjusted[BIN_W + i*BCD_W +: BCD_W] = dd_adjust(shreg_q[BIN_W + i*BCD_W +: BCD_W]);
        end
        stepped = adjusted << 1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = {{BCD_ALL_W{1'b0}}, bin};
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                shreg_d = stepped;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == CONV);
    // Result of the step taking place on this edge, so the caller can commit
    // it on the same edge that ends the conversion.
    assign bcd  = stepped[SR_W-1 -: BCD_ALL_W];

endmodule

// File: rtl/fnd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// fnd_scan_ctrl
// Front end for the 4-digit FND path: saturates and converts a binary value to
// BCD, holds the digits in display registers and time-multiplexes them with
// leading-zero blanking onto a digit select / BCD value / enable triple.
//
// Parameters:
//   CLK_HZ   input clock frequency
//   SCAN_HZ  per-digit scan rate; CLK_HZ/SCAN_HZ must be at least 2
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  synchronous active-high reset, priority over everything
//   bus      fnd_scan_if.slave: i_value/i_load in, o_busy/o_overflow and the
//            registered o_digitSelect/o_bcd/o_en out
// -----------------------------------------------------------------------------
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 1000
) (
    input  logic     i_clk,
    input  logic     i_reset,
    fnd_scan_if.slave bus
);

    localparam int unsigned DIV    = CLK_HZ / SCAN_HZ;
    localparam int unsigned TICK_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [BIN_W-1:0]  SAT_VALUE = BIN_W'(MAX_VALUE);

    // ---------------------------------------------------------------------
    // Capture and conversion
    // ---------------------------------------------------------------------
    logic                               conv_busy;
    logic                               conv_done;
    logic [NUM_DIGITS*BCD_W-1:0]        conv_bcd;
    logic                               start;
    logic [BIN_W-1:0]                   sat_value;
    logic                               sat_flag;
    logic                               overflow_q;

    // A load seen while busy is dropped, not queued.
    assign start     = bus.i_load && !conv_busy;
    assign sat_flag  = (bus.i_value > SAT_VALUE);
    assign sat_value = sat_flag ? SAT_VALUE : bus.i_value;

    bin2bcd_seq u_bin2bcd (
        .clk   (i_clk),
        .reset (i_reset),
        .start (start),
        .bin   (sat_value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            overflow_q <= 1'b0;
        end else if (start) begin
            overflow_q <= sat_flag;
        end
    end

    // ---------------------------------------------------------------------
    // Display registers: all four digits replaced together on commit
    // ---------------------------------------------------------------------
    logic [NUM_DIGITS-1:0][BCD_W-1:0] digits_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            digits_q <= '0;
        end else if (conv_done) begin
            digits_q <= conv_bcd;
        end
    end

    // ---------------------------------------------------------------------
    // Scan timing
    // ---------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    logic [1:0]        sel_q;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tick_cnt_q <= '0;
            sel_q      <= 2'd0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            if (tick) begin
                sel_q <= sel_q + 2'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Blanking and output registers
    // ---------------------------------------------------------------------
    logic             en_next;
    logic [BCD_W-1:0] bcd_next;

    // Digit n is lit if it is digit 0 or any digit at or above it is nonzero.
    always_comb begin
        en_next  = (sel_q == 2'd0);
        bcd_next = digits_q[sel_q];
        for (int m = 0; m < NUM_DIGITS; m++) begin
            if (m >= int'(sel_q) && digits_q[m] != '0) begin
                en_next = 1'b1;
            end
        end
    end

    logic [1:0]       out_sel_q;
    logic [BCD_W-1:0] out_bcd_q;
    logic             out_en_q;

    // Registered every cycle from one select value, so the three outputs
    // always agree and fresh digits show up one cycle after a commit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_sel_q <= 2'd0;
            out_bcd_q <= '0;
            out_en_q  <= 1'b1;
        end else begin
            out_sel_q <= sel_q;
            out_bcd_q <= bcd_next;
            out_en_q  <= en_next;
        end
    end

    assign bus.o_busy        = conv_busy;
    assign bus.o_overflow    = overflow_q;
    assign bus.o_digitSelect = out_sel_q;
    assign bus.o_bcd         = out_bcd_q;
    assign bus.o_en          = out_en_q;

endmodule
